// File: rtl/cpu_sequencer.sv
// Multi-cycle control sequencer for the 16-bit CPU: fetch/decode/execute strobes, halt,
// memory-wait timeout and retired-instruction count. Optional single-step: SEQ_SINGLE_STEP_EN.
module cpu_sequencer #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic [15:0]      mem_rdata,
  input  logic             mem_ready,
  input  logic             halt_req,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic             step_mode,
  input  logic             step,
`endif
  output logic [15:0]      ir,
  output logic             ir_load,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic             addr_sel,
  output logic             rf_we,
  output logic             wb_sel,
  output logic             psr_we,
  output logic             pc_en,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired,
  output logic             bus_err
);

  localparam int TO_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [15:0]      r_ir;
  logic [CNT_W-1:0] r_retired;
  logic             r_bus_err;
  logic [TO_W-1:0]  r_tcnt;

  logic [3:0] w_opcode;
  logic [3:0] w_ext;
  logic       w_is_mem;
  logic       w_is_load;
  logic       w_is_jump;
  logic       w_is_cmp;
  logic       w_is_mov;
  logic       w_halt_at_retire;
  logic       w_leave_halt;
  logic       w_timeout;
  logic       w_ir_load;
  logic       w_mem_rd;
  logic       w_mem_wr;
  logic       w_addr_sel;
  logic       w_rf_we;
  logic       w_wb_sel;
  logic       w_psr_we;
  logic       w_pc_en;

  // Instruction classification straight from the latched IR.
  assign w_opcode  = r_ir[15:12];
  assign w_ext     = r_ir[7:4];
  assign w_is_mem  = (w_opcode == 4'h4) && ((w_ext == 4'h0) || (w_ext == 4'h4));
  assign w_is_load = (w_ext == 4'h0);
  assign w_is_jump = ((w_opcode == 4'h4) && !w_is_mem) || (w_opcode == 4'hC);
  assign w_is_cmp  = ((w_opcode == 4'h0) && (w_ext == 4'hB)) || (w_opcode == 4'hB);
  assign w_is_mov  = ((w_opcode == 4'h0) && (w_ext == 4'hD)) || (w_opcode == 4'hD);

`ifdef SEQ_SINGLE_STEP_EN
  assign w_halt_at_retire = halt_req | step_mode;
  assign w_leave_halt     = !r_bus_err && (step || (!halt_req && !step_mode));
`else
  assign w_halt_at_retire = halt_req;
  assign w_leave_halt     = !r_bus_err && !halt_req;
`endif

  always_comb begin
    // NOTE: every output of this block gets a default before the case so no path can infer a latch.
    w_next     = r_state;
    w_timeout  = 1'b0;
    w_ir_load  = 1'b0;
    w_mem_rd   = 1'b0;
    w_mem_wr   = 1'b0;
    w_addr_sel = 1'b0;
    w_rf_we    = 1'b0;
    w_wb_sel   = 1'b0;
    w_psr_we   = 1'b0;
    w_pc_en    = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_mem_rd = 1'b1;
        if (mem_ready) begin
          w_ir_load = 1'b1;
          w_next    = S_DECODE;
        end else if (r_tcnt == TO_LAST) begin
          w_timeout = 1'b1;
          w_next    = S_HALT;
        end
      end
      S_DECODE: w_next = S_EXEC;
      S_EXEC: begin
        if (w_is_mem) begin
          w_next = S_MEM;
        end else begin
          w_pc_en = 1'b1;
          if (w_is_cmp) begin
            w_psr_we = 1'b1;
          end else if (w_is_mov) begin
            w_rf_we = 1'b1;
          end else if (!w_is_jump) begin
            w_rf_we  = 1'b1;
            w_psr_we = 1'b1;
          end
        end
      end
      S_MEM: begin
        w_addr_sel = 1'b1;
        w_mem_rd   = w_is_load;
        w_mem_wr   = !w_is_load;
        if (mem_ready) begin
          if (w_is_load) w_next  = S_WB;
          else           w_pc_en = 1'b1;
        end else if (r_tcnt == TO_LAST) begin
          w_timeout = 1'b1;
          w_next    = S_HALT;
        end
      end
      S_WB: begin
        w_rf_we  = 1'b1;
        w_wb_sel = 1'b1;
        w_pc_en  = 1'b1;
      end
      S_HALT: if (w_leave_halt) w_next = S_FETCH;
      default: w_next = S_FETCH;
    endcase
    // Retire is the single point where halt is sampled.
    if (w_pc_en) w_next = w_halt_at_retire ? S_HALT : S_FETCH;
  end

  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous, so it is the first branch and overrides any in-flight access.
    if (!Reset) begin
      r_state   <= S_FETCH;
      r_ir      <= '0;
      r_retired <= '0;
      r_bus_err <= 1'b0;
      r_tcnt    <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignment so all of them update from pre-edge values.
      r_state <= w_next;
      if (w_ir_load) r_ir      <= mem_rdata;
      if (w_pc_en)   r_retired <= r_retired + CNT_W'(1);
      if (w_timeout) r_bus_err <= 1'b1;
      if (w_next != r_state)
        r_tcnt <= '0;
      else if (((r_state == S_FETCH) || (r_state == S_MEM)) && !mem_ready)
        r_tcnt <= r_tcnt + TO_W'(1);
    end
  end

  // Strobes are suppressed while Reset is low so nothing leaks out of the reset cycle.
  assign ir_load  = w_ir_load  & Reset;
  assign mem_rd   = w_mem_rd   & Reset;
  assign mem_wr   = w_mem_wr   & Reset;
  assign addr_sel = w_addr_sel & Reset;
  assign rf_we    = w_rf_we    & Reset;
  assign wb_sel   = w_wb_sel   & Reset;
  assign psr_we   = w_psr_we   & Reset;
  assign pc_en    = w_pc_en    & Reset;
  assign ir       = r_ir;
  assign state    = r_state;
  assign retired  = r_retired;
  assign bus_err  = r_bus_err;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: a per-instruction plan of expected cycles is built
// from instruction class, wait states and halt intent, then replayed and compared each cycle.
module tb_cpu_sequencer;

  localparam int TO = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          Reset = 1'b0;
  logic [15:0]   mem_rdata = '0;
  logic          mem_ready = 1'b0;
  logic          halt_req = 1'b0;
  logic [15:0]   ir;
  logic          ir_load, mem_rd, mem_wr, addr_sel, rf_we, wb_sel, psr_we, pc_en;
  logic [2:0]    state;
  logic [CW-1:0] retired;
  logic          bus_err;

  always #5 clk = ~clk;

  cpu_sequencer #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .Reset(Reset), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .halt_req(halt_req), .ir(ir), .ir_load(ir_load), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .addr_sel(addr_sel), .rf_we(rf_we), .wb_sel(wb_sel), .psr_we(psr_we), .pc_en(pc_en),
    .state(state), .retired(retired), .bus_err(bus_err)
  );

  typedef enum {C_ALU, C_CMP, C_MOV, C_JMP, C_LOAD, C_STOR} cls_t;

  // One planned clock cycle: inputs to drive and outputs required in that cycle.
  typedef struct {
    logic          rst_n, ready, halt;
    logic [15:0]   rdata;
    logic          ir_load, mem_rd, mem_wr, addr_sel, rf_we, wb_sel, psr_we, pc_en;
    logic [2:0]    st;
    logic [15:0]   ir;
    logic [CW-1:0] ret;
    logic          berr;
  } cyc_t;

  cyc_t        plan[$];
  logic [15:0] m_ir = '0;
  int          m_ret = 0;
  logic        m_berr = 1'b0;
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic cls_t cls_of(input logic [15:0] w);
    logic [3:0] op, ext;
    op  = w[15:12];
    ext = w[7:4];
    case (op)
      4'h4:    return (ext == 4'h0) ? C_LOAD : (ext == 4'h4) ? C_STOR : C_JMP;
      4'hC:    return C_JMP;
      4'hB:    return C_CMP;
      4'hD:    return C_MOV;
      4'h0:    return (ext == 4'hB) ? C_CMP : (ext == 4'hD) ? C_MOV : C_ALU;
      default: return C_ALU;
    endcase
  endfunction

  function automatic logic noise();
    return ($urandom_range(3) == 0);
  endfunction

  // A cycle with every strobe low, random don't-care inputs and the model's current registers.
  function automatic cyc_t idle(input logic [2:0] st);
    cyc_t c;
    c.rst_n = 1'b1;  c.ready = 1'($urandom_range(1));  c.halt = noise();
    c.rdata = 16'($urandom);
    c.ir_load = 0; c.mem_rd = 0; c.mem_wr = 0; c.addr_sel = 0;
    c.rf_we = 0;   c.wb_sel = 0; c.psr_we = 0; c.pc_en = 0;
    c.st = st;  c.ir = m_ir;  c.ret = CW'(m_ret);  c.berr = m_berr;
    return c;
  endfunction

  task automatic fetch(input logic [15:0] w, input int wf);
    cyc_t c;
    for (int i = 0; i < wf; i++) begin
      c = idle(0); c.ready = 0; c.mem_rd = 1; plan.push_back(c);
    end
    c = idle(0); c.ready = 1; c.rdata = w; c.mem_rd = 1; c.ir_load = 1; plan.push_back(c);
    m_ir = w;
    plan.push_back(idle(1));
  endtask

  task automatic mem_wait(input cls_t k, input int n);
    cyc_t c;
    for (int i = 0; i < n; i++) begin
      c = idle(3); c.ready = 0; c.addr_sel = 1;
      c.mem_rd = (k == C_LOAD); c.mem_wr = (k == C_STOR);
      plan.push_back(c);
    end
  endtask

  task automatic instr(input logic [15:0] w, input int wf, input int wm, input logic hlt, input int hold);
    cyc_t c;
    cls_t k;
    k = cls_of(w);
    fetch(w, wf);
    c = idle(2);
    if (k == C_LOAD || k == C_STOR) begin
      plan.push_back(c);
      mem_wait(k, wm);
      c = idle(3); c.ready = 1; c.addr_sel = 1;
      c.mem_rd = (k == C_LOAD); c.mem_wr = (k == C_STOR);
      if (k == C_LOAD) begin
        plan.push_back(c);
        c = idle(4); c.rf_we = 1; c.wb_sel = 1;
      end
    end else begin
      c.rf_we  = (k == C_ALU) || (k == C_MOV);
      c.psr_we = (k == C_ALU) || (k == C_CMP);
    end
    c.pc_en = 1; c.halt = hlt;
    plan.push_back(c);
    m_ret = (m_ret + 1) % (1 << CW);
    if (hlt) begin
      for (int i = 0; i < hold; i++) begin
        c = idle(5); c.halt = 1; plan.push_back(c);
      end
      c = idle(5); c.halt = 0; plan.push_back(c);
    end
  endtask

  task automatic rst(input logic [2:0] cur, input int n);
    cyc_t c;
    c = idle(cur); c.rst_n = 0; plan.push_back(c);
    m_ir = '0; m_ret = 0; m_berr = 1'b0;
    for (int i = 1; i < n; i++) begin
      c = idle(0); c.rst_n = 0; plan.push_back(c);
    end
  endtask

  // Timeout in FETCH (in_mem=0) or in MEM of a LOAD (in_mem=1), then sit in HALT.
  task automatic timeout(input logic in_mem);
    cyc_t c;
    if (in_mem) begin
      fetch(16'h4A05, 0);
      plan.push_back(idle(2));
      mem_wait(C_LOAD, TO);
    end else begin
      for (int i = 0; i < TO; i++) begin
        c = idle(0); c.ready = 0; c.mem_rd = 1; plan.push_back(c);
      end
    end
    m_berr = 1'b1;
    for (int i = 0; i < 4; i++) begin
      c = idle(5); c.halt = 0; plan.push_back(c);
    end
    rst(5, 2);
  endtask

  task automatic play();
    cyc_t c;
    while (plan.size() > 0) begin
      c = plan.pop_front();
      Reset = c.rst_n; mem_ready = c.ready; halt_req = c.halt; mem_rdata = c.rdata;
      @(negedge clk);
      check("state",    32'(state),    32'(c.st));
      check("ir",       32'(ir),       32'(c.ir));
      check("retired",  32'(retired),  32'(c.ret));
      check("bus_err",  32'(bus_err),  32'(c.berr));
      check("ir_load",  32'(ir_load),  32'(c.ir_load));
      check("mem_rd",   32'(mem_rd),   32'(c.mem_rd));
      check("mem_wr",   32'(mem_wr),   32'(c.mem_wr));
      check("addr_sel", 32'(addr_sel), 32'(c.addr_sel));
      check("rf_we",    32'(rf_we),    32'(c.rf_we));
      check("wb_sel",   32'(wb_sel),   32'(c.wb_sel));
      check("psr_we",   32'(psr_we),   32'(c.psr_we));
      check("pc_en",    32'(pc_en),    32'(c.pc_en));
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int n0;
    logic [15:0] w;
    logic [3:0]  op, ext;
    @(posedge clk);
    #1;
    rst(0, 2);

    // Directed sequences; plan lengths pin the model's latency rules.
    n0 = plan.size(); instr(16'h0152, 0, 0, 0, 0);
    check("pin_len_add", 32'(plan.size() - n0), 3);
    play();
    check("pin_add_retired", 32'(retired), 1);
    check("pin_add_state", 32'(state), 0);

    n0 = plan.size(); instr(16'h4305, 0, 2, 0, 0);
    check("pin_len_load_2ws", 32'(plan.size() - n0), 7);
    n0 = plan.size(); instr(16'h4345, 0, 0, 0, 0);
    check("pin_len_stor", 32'(plan.size() - n0), 4);
    n0 = plan.size(); instr(16'hC0FE, 0, 0, 0, 0);
    check("pin_len_bcond", 32'(plan.size() - n0), 3);
    n0 = plan.size(); instr(16'h0152, 0, 0, 1, 2);
    plan[n0 + 1].halt = 1'b1;
    check("pin_len_halt", 32'(plan.size() - n0), 6);
    instr(16'h1234, TO - 1, 0, 0, 0);
    instr(16'h4105, 1, TO - 1, 0, 0);
    play();
    check("pin_retired_7", 32'(retired), 7);

    timeout(1'b0);
    timeout(1'b1);
    // Reset in the middle of a LOAD's MEM phase.
    fetch(16'h4305, 0);
    plan.push_back(idle(2));
    mem_wait(C_LOAD, 1);
    rst(3, 2);
    play();
    check("pin_after_abort_retired", 32'(retired), 0);

    // Randomized instruction stream.
    for (int i = 0; i < 250; i++) begin
      op = 4'($urandom_range(15));
      case ($urandom_range(4))
        0: ext = 4'h0;
        1: ext = 4'h4;
        2: ext = 4'hB;
        3: ext = 4'hD;
        default: ext = 4'($urandom_range(15));
      endcase
      w = {op, 4'($urandom_range(15)), ext, 4'($urandom_range(15))};
      if ($urandom_range(39) == 0) timeout(1'($urandom_range(1)));
      instr(w,
            ($urandom_range(9) == 0) ? TO - 1 : $urandom_range(3),
            ($urandom_range(9) == 0) ? TO - 1 : $urandom_range(3),
            ($urandom_range(7) == 0), $urandom_range(2));
    end
    play();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
